// File: rtl/pic_debug_bridge.sv
// pic_debug_bridge: host debug initiator for the PIC16C5x register file.
// Takes byte-framed read/write commands from a host stream, halts the core
// with a haltReq/haltAck handshake, performs one register-file access and
// returns read data on the host output stream.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   hostInData/Valid/Ready    command/data byte stream from the host
//   hostOutData/Valid/Ready   response byte stream to the host
//   haltReq, haltAck          core halt request / halted acknowledge
//   writeCommand              register-file command (3'b010 write, 3'b000 idle)
//   fileAddr, writeDataOut    register-file address and write data
//   regfileIn                 register-file combinational read data
//   busy                      bridge is not idle
//   timeoutErr                sticky halt-timeout flag
//
// Command byte: bit7 W (1 write), bit6 HOLD (keep core halted), bit5 ignored,
// bits4:0 file address. A write frame carries one extra data byte.
module pic_debug_bridge #(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 5,
  parameter int unsigned           HALT_TIMEOUT = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_BYTE     = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] hostInData,
  input  logic                  hostInValid,
  output logic                  hostInReady,
  output logic [DATA_WIDTH-1:0] hostOutData,
  output logic                  hostOutValid,
  input  logic                  hostOutReady,
  output logic                  haltReq,
  input  logic                  haltAck,
  output logic [2:0]            writeCommand,
  output logic [ADDR_WIDTH-1:0] fileAddr,
  output logic [DATA_WIDTH-1:0] writeDataOut,
  input  logic [DATA_WIDTH-1:0] regfileIn,
  output logic                  busy,
  output logic                  timeoutErr
);

  localparam int unsigned CNT_W = (HALT_TIMEOUT < 1) ? 1 : $clog2(HALT_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_DATA  = 3'd1;
  localparam logic [2:0] S_HALT_WAIT = 3'd2;
  localparam logic [2:0] S_ACCESS    = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;
  localparam logic [2:0] S_RELEASE   = 3'd5;
  localparam logic [2:0] S_ABORT     = 3'd6;

  localparam logic [2:0] WCMD_IDLE  = 3'b000;
  localparam logic [2:0] WCMD_WRITE = 3'b010;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  w_q, w_d;
  logic                  hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  halt_q, halt_d;
  logic                  terr_q, terr_d;
  logic [2:0]            wcmd_q, wcmd_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  in_hs;

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      w_q         <= 1'b0;
      hold_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      halt_q      <= 1'b0;
      terr_q      <= 1'b0;
      wcmd_q      <= WCMD_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      hold_q      <= hold_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      halt_q      <= halt_d;
      terr_q      <= terr_d;
      wcmd_q      <= wcmd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    halt_d  = halt_q;
    terr_d  = terr_q;
    wcmd_d  = WCMD_IDLE;
    in_hs   = hostInValid && in_ready_q;

    case (state_q)
      S_IDLE: begin
        if (in_hs) begin
          addr_d  = hostInData[ADDR_WIDTH-1:0];
          w_d     = hostInData[DATA_WIDTH-1];
          hold_d  = hostInData[DATA_WIDTH-2];
          terr_d  = 1'b0;
          state_d = hostInData[DATA_WIDTH-1] ? S_GET_DATA : S_HALT_WAIT;
        end
      end
      S_GET_DATA: begin
        if (in_hs) begin
          wdata_d = hostInData;
          state_d = S_HALT_WAIT;
        end
      end
      S_HALT_WAIT: begin
        // Acknowledge wins over a timeout landing in the same cycle
        if (haltAck) begin
          state_d = S_ACCESS;
        end else if (cnt_q == CNT_W'(HALT_TIMEOUT)) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACCESS: begin
        if (w_q) begin
          state_d = S_RELEASE;
        end else begin
          rdata_d = regfileIn;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (hostOutReady) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // AND with halt_q so a HOLD after an abort never re-raises haltReq
        halt_d  = halt_q & hold_q;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        terr_d = 1'b1;
        halt_d = 1'b0;
        if (w_q) begin
          state_d = S_IDLE;
        end else begin
          rdata_d = ERR_BYTE;
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Entry into HALT_WAIT: restart the timeout and request the halt
    if ((state_d == S_HALT_WAIT) && (state_q != S_HALT_WAIT)) begin
      cnt_d  = '0;
      halt_d = 1'b1;
    end

    if ((state_d == S_ACCESS) && w_q) begin
      wcmd_d = WCMD_WRITE;
    end

    in_ready_d  = (state_d == S_IDLE) || (state_d == S_GET_DATA);
    out_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  assign hostInReady  = in_ready_q;
  assign hostOutData  = rdata_q;
  assign hostOutValid = out_valid_q;
  assign haltReq      = halt_q;
  assign writeCommand = wcmd_q;
  assign fileAddr     = addr_q;
  assign writeDataOut = wdata_q;
  assign busy         = busy_q;
  assign timeoutErr   = terr_q;

endmodule

// File: tb/tb_pic_debug_bridge.sv
// Directed testbench for pic_debug_bridge: write, read with backpressure,
// HOLD across frames, read/write halt timeouts and reset mid-frame.
module tb_pic_debug_bridge;

  logic       clk;
  logic       rst;
  logic [7:0] hostInData;
  logic       hostInValid;
  logic       hostInReady;
  logic [7:0] hostOutData;
  logic       hostOutValid;
  logic       hostOutReady;
  logic       haltReq;
  logic       haltAck;
  logic [2:0] writeCommand;
  logic [4:0] fileAddr;
  logic [7:0] writeDataOut;
  logic [7:0] regfileIn;
  logic       busy;
  logic       timeoutErr;

  int n_tests;
  int n_fail;
  int wc_pulses;
  int hold_drops;
  logic watch_hold;

  pic_debug_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .hostInData   (hostInData),
    .hostInValid  (hostInValid),
    .hostInReady  (hostInReady),
    .hostOutData  (hostOutData),
    .hostOutValid (hostOutValid),
    .hostOutReady (hostOutReady),
    .haltReq      (haltReq),
    .haltAck      (haltAck),
    .writeCommand (writeCommand),
    .fileAddr     (fileAddr),
    .writeDataOut (writeDataOut),
    .regfileIn    (regfileIn),
    .busy         (busy),
    .timeoutErr   (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write pulses and any haltReq dip inside a HOLD window
  always @(negedge clk) begin
    if (writeCommand == 3'b010) wc_pulses++;
    if (watch_hold && !haltReq) hold_drops++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; wc_pulses = 0; hold_drops = 0; watch_hold = 1'b0;
    rst = 1'b1; hostInData = 8'h00; hostInValid = 1'b0; hostOutReady = 1'b0;
    haltAck = 1'b0; regfileIn = 8'h00;

    // Reset state
    tick(); tick();
    check("rst_in_ready",  32'(hostInReady), 32'd0);
    check("rst_out_valid", 32'(hostOutValid), 32'd0);
    check("rst_out_data",  32'(hostOutData), 32'h00);
    check("rst_halt",      32'(haltReq), 32'd0);
    check("rst_wcmd",      32'(writeCommand), 32'd0);
    check("rst_addr",      32'(fileAddr), 32'd0);
    check("rst_wdata",     32'(writeDataOut), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_terr",      32'(timeoutErr), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(hostInReady), 32'd1);

    // Write 0x8C,0x5A with haltAck high
    haltAck = 1'b1;
    hostInData = 8'h8C; hostInValid = 1'b1;
    tick();
    check("wr_busy",      32'(busy), 32'd1);
    check("wr_getdata_rdy", 32'(hostInReady), 32'd1);
    check("wr_addr",      32'(fileAddr), 32'h0C);
    hostInData = 8'h5A;
    tick();
    hostInValid = 1'b0;
    check("wr_halt_req",  32'(haltReq), 32'd1);
    check("wr_hw_rdy",    32'(hostInReady), 32'd0);
    check("wr_hw_wcmd",   32'(writeCommand), 32'd0);
    tick();
    check("wr_pulse",     32'(writeCommand), 32'h2);
    check("wr_pulse_addr", 32'(fileAddr), 32'h0C);
    check("wr_pulse_data", 32'(writeDataOut), 32'h5A);
    tick();
    check("wr_release_wcmd", 32'(writeCommand), 32'd0);
    check("wr_release_halt", 32'(haltReq), 32'd1);
    tick();
    check("wr_idle_halt", 32'(haltReq), 32'd0);
    check("wr_idle_busy", 32'(busy), 32'd0);
    check("wr_idle_rdy",  32'(hostInReady), 32'd1);
    check("wr_one_pulse", 32'(wc_pulses), 32'd1);

    // Read 0x0C with four cycles of output backpressure
    regfileIn = 8'h5A;
    hostInData = 8'h0C; hostInValid = 1'b1;
    tick();
    hostInValid = 1'b0;
    check("rd_halt_req", 32'(haltReq), 32'd1);
    check("rd_hw_valid", 32'(hostOutValid), 32'd0);
    tick();
    check("rd_acc_valid", 32'(hostOutValid), 32'd0);
    check("rd_acc_wcmd",  32'(writeCommand), 32'd0);
    tick();
    regfileIn = 8'h33;
    check("rd_resp_valid", 32'(hostOutValid), 32'd1);
    check("rd_resp_data",  32'(hostOutData), 32'h5A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_hold_valid", 32'(hostOutValid), 32'd1);
      check("rd_hold_data",  32'(hostOutData), 32'h5A);
    end
    hostOutReady = 1'b1;
    tick();
    hostOutReady = 1'b0;
    check("rd_after_hs_valid", 32'(hostOutValid), 32'd0);
    tick();
    check("rd_idle_halt", 32'(haltReq), 32'd0);
    check("rd_idle_busy", 32'(busy), 32'd0);

    // HOLD read 0x46 then read 0x07: haltReq must never dip
    regfileIn = 8'h11;
    hostInData = 8'h46; hostInValid = 1'b1;
    tick();
    hostInValid = 1'b0;
    watch_hold = 1'b1;
    check("hold1_halt", 32'(haltReq), 32'd1);
    tick(); tick();
    check("hold1_data", 32'(hostOutData), 32'h11);
    hostOutReady = 1'b1;
    tick();
    hostOutReady = 1'b0;
    tick();
    check("hold_idle_halt", 32'(haltReq), 32'd1);
    check("hold_idle_busy", 32'(busy), 32'd0);
    check("hold_idle_addr", 32'(fileAddr), 32'h06);
    regfileIn = 8'h22;
    hostInData = 8'h07; hostInValid = 1'b1;
    tick();
    hostInValid = 1'b0;
    tick(); tick();
    check("hold2_data", 32'(hostOutData), 32'h22);
    hostOutReady = 1'b1;
    tick();
    hostOutReady = 1'b0;
    check("hold2_release_halt", 32'(haltReq), 32'd1);
    watch_hold = 1'b0;
    tick();
    check("hold2_idle_halt", 32'(haltReq), 32'd0);
    check("hold_no_dip", 32'(hold_drops), 32'd0);

    // Read 0x10 with haltAck stuck low: abort after 256 HALT_WAIT cycles
    haltAck = 1'b0;
    hostInData = 8'h10; hostInValid = 1'b1;
    tick();
    hostInValid = 1'b0;
    repeat (255) tick();
    check("ab_rd_wait_halt",  32'(haltReq), 32'd1);
    check("ab_rd_wait_valid", 32'(hostOutValid), 32'd0);
    check("ab_rd_wait_terr",  32'(timeoutErr), 32'd0);
    tick();
    check("ab_rd_abort_valid", 32'(hostOutValid), 32'd0);
    tick();
    check("ab_rd_resp_valid", 32'(hostOutValid), 32'd1);
    check("ab_rd_resp_data",  32'(hostOutData), 32'hEE);
    check("ab_rd_terr",       32'(timeoutErr), 32'd1);
    check("ab_rd_halt",       32'(haltReq), 32'd0);
    check("ab_rd_no_pulse",   32'(wc_pulses), 32'd1);
    hostOutReady = 1'b1;
    tick();
    hostOutReady = 1'b0;
    tick();
    check("ab_rd_idle_busy", 32'(busy), 32'd0);
    check("ab_rd_sticky",    32'(timeoutErr), 32'd1);
    check("ab_rd_idle_halt", 32'(haltReq), 32'd0);

    // Write 0x90,0xFF with haltAck low: dropped, no pulse, no response
    hostInData = 8'h90; hostInValid = 1'b1;
    tick();
    check("ab_wr_terr_clr", 32'(timeoutErr), 32'd0);
    check("ab_wr_addr",     32'(fileAddr), 32'h10);
    hostInData = 8'hFF;
    tick();
    hostInValid = 1'b0;
    repeat (256) tick();
    check("ab_wr_abort_halt", 32'(haltReq), 32'd1);
    tick();
    check("ab_wr_idle_busy",  32'(busy), 32'd0);
    check("ab_wr_halt",       32'(haltReq), 32'd0);
    check("ab_wr_terr",       32'(timeoutErr), 32'd1);
    check("ab_wr_no_resp",    32'(hostOutValid), 32'd0);
    check("ab_wr_rdy",        32'(hostInReady), 32'd1);
    check("ab_wr_wcmd",       32'(writeCommand), 32'd0);
    check("ab_wr_no_pulse",   32'(wc_pulses), 32'd1);

    // Reset asserted during HALT_WAIT: outputs drop without a clock edge
    hostInData = 8'h03; hostInValid = 1'b1;
    tick();
    hostInValid = 1'b0;
    check("mid_halt", 32'(haltReq), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_halt",  32'(haltReq), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_rdy",   32'(hostInReady), 32'd0);
    check("mid_rst_addr",  32'(fileAddr), 32'd0);
    check("mid_rst_wdata", 32'(writeDataOut), 32'd0);
    check("mid_rst_odata", 32'(hostOutData), 32'd0);
    check("mid_rst_wcmd",  32'(writeCommand), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_post_rdy",   32'(hostInReady), 32'd1);
    check("mid_post_pulse", 32'(wc_pulses), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
